// File: rtl/msg_stream_arbiter.sv
`timescale 1ns/1ps
// msg_stream_arbiter
// Round-robin, packet-granular arbiter that merges NUM_SRC 64-bit Avalon-ST
// feeds into the single input of a msg_extractor_fsm. A source is held from
// startofpacket to endofpacket so headers and payload never interleave.
// Beats leave through a registered output stage; out_channel names the owner.
// Optional feature: define PKT_TIMEOUT_EN to add a stall watchdog that closes
// a packet with an error beat when the granted source goes quiet.
module msg_stream_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int CH_W    = 2,
  parameter int TO_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_SRC-1:0]    in_valid,
  input  logic [64*NUM_SRC-1:0] in_data,
  input  logic [NUM_SRC-1:0]    in_startofpacket,
  input  logic [NUM_SRC-1:0]    in_endofpacket,
  input  logic [3*NUM_SRC-1:0]  in_empty,
  input  logic [NUM_SRC-1:0]    in_error,
  output logic [NUM_SRC-1:0]    in_ready,
  output logic                  out_valid,
  output logic [63:0]           out_data,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic [2:0]            out_empty,
  output logic                  out_error,
  output logic [CH_W-1:0]       out_channel,
  input  logic                  out_ready
);

  // Reject configurations the channel index or watchdog cannot represent.
  if (NUM_SRC < 2 || NUM_SRC > 8 || (1 << CH_W) < NUM_SRC || TO_W < 1) begin : g_bad_params
    $error("msg_stream_arbiter: illegal NUM_SRC/CH_W/TO_W combination");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;

  logic               ld;
  logic               accept;
  logic [NUM_SRC-1:0] req;
  logic               any_req;
  logic [CH_W-1:0]    winner;

  // Fields of the granted source's current beat.
  logic        g_valid;
  logic [63:0] g_data;
  logic        g_sop;
  logic        g_eop;
  logic [2:0]  g_empty;
  logic        g_error;

  // Beat to be captured by the output register.
  logic        beat_load;
  logic [63:0] nxt_data;
  logic        nxt_sop;
  logic        nxt_eop;
  logic [2:0]  nxt_empty;
  logic        nxt_error;

  // Round-robin successor; wraps by comparison so NUM_SRC need not be 2**CH_W.
  function automatic logic [CH_W-1:0] next_ptr(input logic [CH_W-1:0] cur);
    if (cur == CH_W'(NUM_SRC - 1)) return '0;
    return cur + CH_W'(1);
  endfunction

  assign ld      = out_ready | ~out_valid;
  assign req     = in_valid & in_startofpacket;
  assign accept  = (state_q == BUSY) & g_valid & ld;

  // Pick the first requester at or above rr_ptr, else the lowest one below it.
  always_comb begin : rr_pick
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    winner  = '0;
    any_req = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!any_req && req[i] && (CH_W'(i) >= rr_ptr_q)) begin
        any_req = 1'b1;
        winner  = CH_W'(i);
      end
    end
    // Any request left unclaimed is below rr_ptr: this is the wrap-around.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!any_req && req[i]) begin
        any_req = 1'b1;
        winner  = CH_W'(i);
      end
    end
  end

  // Select the granted source's beat fields.
  always_comb begin : grant_mux
    g_valid = 1'b0;
    g_data  = '0;
    g_sop   = 1'b0;
    g_eop   = 1'b0;
    g_empty = '0;
    g_error = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == CH_W'(i)) begin
        g_valid = in_valid[i];
        g_data  = in_data[64*i +: 64];
        g_sop   = in_startofpacket[i];
        g_eop   = in_endofpacket[i];
        g_empty = in_empty[3*i +: 3];
        g_error = in_error[i];
      end
    end
  end

`ifdef PKT_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q;
  logic            to_fire;

  // Granted source idle long enough with the output free: close the packet.
  assign to_fire = (state_q == BUSY) & ~g_valid & ld & (to_cnt_q == '1);

  // Stall watchdog: counts idle cycles of the granted source while BUSY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else if (state_q != BUSY || accept || to_fire) begin
      to_cnt_q <= '0;
    end else if (!g_valid && ld) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end
`endif

  // FSM next state, per-source ready and the beat offered to the output stage.
  always_comb begin : fsm_next
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    in_ready  = '0;
    beat_load = 1'b0;
    nxt_data  = g_data;
    nxt_sop   = g_sop;
    nxt_eop   = g_eop;
    nxt_empty = g_empty;
    nxt_error = g_error;
    case (state_q)
      IDLE: begin
        // Beats without SOP cannot start a packet; drain them so they never
        // block a feed. Requesters wait a cycle for the grant to register.
        in_ready = in_valid & ~in_startofpacket;
        if (any_req) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (grant_q == CH_W'(i)) in_ready[i] = ld;
        end
        if (accept) begin
          beat_load = 1'b1;
          if (g_eop) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr(grant_q);
          end
        end
`ifdef PKT_TIMEOUT_EN
        else if (to_fire) begin
          beat_load = 1'b1;
          nxt_data  = '0;
          nxt_sop   = 1'b0;
          nxt_eop   = 1'b1;
          nxt_empty = '0;
          nxt_error = 1'b1;
          state_d   = IDLE;
          rr_ptr_d  = next_ptr(grant_q);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output register: loads when empty or draining, holds while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= '0;
      out_error         <= 1'b0;
      out_channel       <= '0;
    end else if (ld) begin
      out_valid <= beat_load;
      if (beat_load) begin
        out_data          <= nxt_data;
        out_startofpacket <= nxt_sop;
        out_endofpacket   <= nxt_eop;
        out_empty         <= nxt_empty;
        out_error         <= nxt_error;
        out_channel       <= grant_q;
      end
    end
  end

endmodule

// File: tb/tb_msg_stream_arbiter.sv
`timescale 1ns/1ps
// Testbench for msg_stream_arbiter: per-source drivers feed a scoreboard of
// expected beats per channel; an independent monitor pops and compares every
// beat the DUT hands downstream. Directed scenarios plus a random soak with
// a packet-level fairness model.
module tb_msg_stream_arbiter;

  localparam int NUM_SRC = 4;
  localparam int CH_W    = 2;
  localparam int TO_W    = 4;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NUM_SRC-1:0]    in_valid = '0;
  logic [64*NUM_SRC-1:0] in_data = '0;
  logic [NUM_SRC-1:0]    in_startofpacket = '0;
  logic [NUM_SRC-1:0]    in_endofpacket = '0;
  logic [3*NUM_SRC-1:0]  in_empty = '0;
  logic [NUM_SRC-1:0]    in_error = '0;
  logic [NUM_SRC-1:0]    in_ready;
  logic                  out_valid;
  logic [63:0]           out_data;
  logic                  out_startofpacket;
  logic                  out_endofpacket;
  logic [2:0]            out_empty;
  logic                  out_error;
  logic [CH_W-1:0]       out_channel;
  logic                  out_ready = 1'b0;

  msg_stream_arbiter #(.NUM_SRC(NUM_SRC), .CH_W(CH_W), .TO_W(TO_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_startofpacket (in_startofpacket),
    .in_endofpacket   (in_endofpacket),
    .in_empty         (in_empty),
    .in_error         (in_error),
    .in_ready         (in_ready),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket  (out_endofpacket),
    .out_empty        (out_empty),
    .out_error        (out_error),
    .out_channel      (out_channel),
    .out_ready        (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        orphan;
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic        err;
  } beat_t;

  beat_t src_q [NUM_SRC][$];
  beat_t exp_q [NUM_SRC][$];
  beat_t cur [NUM_SRC];
  bit    presenting [NUM_SRC];
  bit    waiting [NUM_SRC];
  int    waits [NUM_SRC];
  int    out_ch_log[$];
  int    out_cyc_log[$];
  int    ready_pct = 100;
  int    gap_pct = 0;
  int    stall_left = 0;
  int    sample_cyc = 0;
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic beat_t mk(input logic orphan, input logic [63:0] data, input logic sop,
                               input logic eop, input logic [2:0] empty, input logic err);
    beat_t b;
    b.orphan = orphan;
    b.data   = data;
    b.sop    = sop;
    b.eop    = eop;
    b.empty  = empty;
    b.err    = err;
    return b;
  endfunction

  // Queue an n-beat packet on source s; beat k carries data base+k.
  task automatic push_pkt(input int s, input int n, input logic [63:0] base);
    for (int k = 0; k < n; k++) begin
      src_q[s].push_back(mk(1'b0, base + 64'(k), k == 0, k == n - 1,
                            (k == n - 1) ? 3'(k) : 3'd0, 1'b0));
    end
  endtask

  // One clock of stimulus: drive at negedge, sample acceptance just before posedge.
  task automatic step();
    logic [NUM_SRC-1:0] acc;
    @(negedge clk);
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = ($urandom_range(99) < ready_pct);
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      if (!presenting[s] && src_q[s].size() > 0 && $urandom_range(99) >= gap_pct) begin
        cur[s] = src_q[s].pop_front();
        presenting[s] = 1'b1;
      end
      in_valid[s]          = presenting[s];
      in_data[64*s +: 64]  = cur[s].data;
      in_startofpacket[s]  = cur[s].sop;
      in_endofpacket[s]    = cur[s].eop;
      in_empty[3*s +: 3]   = cur[s].empty;
      in_error[s]          = cur[s].err;
    end
    #4;
    sample_cyc = cyc;
    acc = in_valid & in_ready;
    for (int s = 0; s < NUM_SRC; s++)
      if (in_valid[s] && in_startofpacket[s]) waiting[s] = 1'b1;
    for (int c = 0; c < NUM_SRC; c++)
      if (acc[c] && in_startofpacket[c])
        for (int s = 0; s < NUM_SRC; s++)
          if (s != c && waiting[s]) waits[s]++;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (acc[s]) begin
        if (!cur[s].orphan) exp_q[s].push_back(cur[s]);
        if (cur[s].sop) begin
          check_int("fairness_max_wait_ok", int'(waits[s] <= NUM_SRC - 1), 1);
          waiting[s] = 1'b0;
          waits[s]   = 0;
        end
        presenting[s] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n          = 1'b0;
    in_valid         = '0;
    in_startofpacket = '0;
    in_endofpacket   = '0;
    in_data          = '0;
    in_empty         = '0;
    in_error         = '0;
    out_ready        = 1'b0;
    stall_left       = 0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_q[s].delete();
      exp_q[s].delete();
      presenting[s] = 1'b0;
      waiting[s]    = 1'b0;
      waits[s]      = 0;
    end
    #2;
    check("reset_out_regs", {7'b0, out_valid, out_data, out_startofpacket, out_endofpacket,
                             out_empty, out_error, out_channel}, '0);
    check_int("reset_in_ready", int'(in_ready), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    out_ch_log.delete();
    out_cyc_log.delete();
  endtask

  task automatic run_until_logs(input string name, input int n, input int bound);
    int k = 0;
    while (out_ch_log.size() < n && k < bound) begin
      step();
      k++;
    end
    repeat (2) step();
    check_int(name, out_ch_log.size(), n);
  endtask

  function automatic bit pending();
    for (int s = 0; s < NUM_SRC; s++)
      if (src_q[s].size() != 0 || presenting[s] || exp_q[s].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: compares every transferred beat and checks stalled outputs hold.
  initial begin : monitor
    logic [79:0] snap;
    logic [79:0] now_snap;
    bit          have_prev;
    bit          prev_stall;
    bit          in_pkt;
    int          pkt_ch;
    int          ch;
    beat_t       e;
    have_prev = 1'b0;
    in_pkt = 1'b0;
    pkt_ch = 0;
    snap = '0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!reset_n) begin
        have_prev = 1'b0;
        in_pkt    = 1'b0;
      end else begin
        now_snap = {7'b0, out_valid, out_data, out_startofpacket, out_endofpacket,
                    out_empty, out_error, out_channel};
        if (have_prev && prev_stall) check("stall_hold_stable", now_snap, snap);
        if (out_valid && out_ready) begin
          ch = int'(out_channel);
          if (exp_q[ch].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat channel=%0d data=%h required=no_beat", ch, out_data);
          end else begin
            e = exp_q[ch].pop_front();
            check($sformatf("beat_ch%0d", ch),
                  {10'b0, out_data, out_startofpacket, out_endofpacket, out_empty, out_error},
                  {10'b0, e.data, e.sop, e.eop, e.empty, e.err});
          end
          if (out_startofpacket) begin
            check_int("sop_inside_open_packet", int'(in_pkt), 0);
            in_pkt = 1'b1;
            pkt_ch = ch;
          end else if (in_pkt) begin
            check_int("packet_channel_atomic", ch, pkt_ch);
          end
          if (out_endofpacket) in_pkt = 1'b0;
          out_ch_log.push_back(ch);
          out_cyc_log.push_back(cyc);
        end
        snap       = now_snap;
        prev_stall = out_valid && !out_ready;
        have_prev  = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "testbench timeout");
  end

  initial begin : stimulus
    int t_sop;
    int exp_seq [6];
    beat_t b;
    repeat (2) @(negedge clk);

    // Single 3-beat packet from source 0: latency 2 from SOP to first output.
    do_reset();
    src_q[0].push_back(mk(1'b0, 64'h1111_1111_1111_1111, 1'b1, 1'b0, 3'd0, 1'b0));
    src_q[0].push_back(mk(1'b0, 64'h2222_2222_2222_2222, 1'b0, 1'b0, 3'd0, 1'b0));
    src_q[0].push_back(mk(1'b0, 64'h3333_3333_3333_3333, 1'b0, 1'b1, 3'd5, 1'b0));
    step();
    t_sop = sample_cyc;
    run_until_logs("t1_beat_count", 3, 20);
    if (out_cyc_log.size() > 0) check_int("t1_sop_to_out_latency", out_cyc_log[0] - t_sop, 2);
    foreach (out_ch_log[i]) check_int("t1_channel", out_ch_log[i], 0);

    // rr_ptr now 1: simultaneous requests from 0 and 1 go to 1 first.
    out_ch_log.delete();
    out_cyc_log.delete();
    push_pkt(0, 1, 64'h0A00);
    push_pkt(1, 1, 64'h0B00);
    run_until_logs("t1b_beat_count", 2, 20);
    if (out_ch_log.size() == 2) begin
      check_int("t1b_rr_first", out_ch_log[0], 1);
      check_int("t1b_rr_second", out_ch_log[1], 0);
    end

    // Three sources with back-to-back single-beat packets: 0,1,2,0,1,2.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 3; s++) push_pkt(s, 1, {8'(s), 8'(r), 48'h5A5A});
    run_until_logs("t2_beat_count", 6, 40);
    if (out_ch_log.size() == 6) begin
      for (int i = 0; i < 6; i++) check_int("t2_rr_order", out_ch_log[i], i % 3);
      for (int i = 1; i < 6; i++) check_int("t2_bubble_spacing", out_cyc_log[i] - out_cyc_log[i-1], 2);
    end

    // Source 3 packet in flight; source 1 must wait for its EOP.
    do_reset();
    push_pkt(3, 4, 64'h3300_0000_0000_0000);
    step();
    step();
    push_pkt(1, 2, 64'h1100_0000_0000_0000);
    run_until_logs("t3_beat_count", 6, 40);
    exp_seq = '{3, 3, 3, 3, 1, 1};
    if (out_ch_log.size() == 6)
      for (int i = 0; i < 6; i++) check_int("t3_no_interleave", out_ch_log[i], exp_seq[i]);

    // Downstream stall of 4 cycles mid-packet: hold output, no loss or duplicate.
    do_reset();
    push_pkt(0, 5, 64'hC0DE_0000_0000_0000);
    repeat (4) step();
    stall_left = 4;
    repeat (4) begin
      step();
      check_int("t4_stall_in_ready_grant", int'(in_ready[0]), 0);
      check_int("t4_stall_out_valid", int'(out_valid), 1);
    end
    run_until_logs("t4_beat_count", 5, 40);

    // Orphan beat in IDLE is flushed and never forwarded.
    do_reset();
    src_q[2].push_back(mk(1'b1, 64'hDEAD, 1'b0, 1'b0, 3'd0, 1'b0));
    step();
    check_int("t5_orphan_ready", int'(in_ready[2]), 1);
    repeat (3) begin
      step();
      check_int("t5_orphan_no_output", int'(out_valid), 0);
    end
    check_int("t5_orphan_log_empty", out_ch_log.size(), 0);

    // Reset while a packet is in flight, then normal operation from scratch.
    do_reset();
    push_pkt(1, 4, 64'hBEEF_0000_0000_0000);
    repeat (4) step();
    check_int("t6_inflight_before_reset", int'(out_valid), 1);
    do_reset();
    push_pkt(2, 1, 64'h2200);
    run_until_logs("t6_after_reset_count", 1, 20);
    if (out_ch_log.size() == 1) check_int("t6_after_reset_channel", out_ch_log[0], 2);

`ifdef PKT_TIMEOUT_EN
    // Granted source sends SOP then stalls: watchdog closes with an error beat.
    do_reset();
    src_q[0].push_back(mk(1'b0, 64'hABCD_0000_0000_0001, 1'b1, 1'b0, 3'd0, 1'b0));
    for (int k = 0; k < 10 && (presenting[0] || src_q[0].size() != 0); k++) step();
    exp_q[0].push_back(mk(1'b0, 64'h0, 1'b0, 1'b1, 3'd0, 1'b1));
    run_until_logs("t7_timeout_beat_count", 2, 40);
    if (out_cyc_log.size() == 2)
      check_int("t7_timeout_delay_15_to_17",
                int'((out_cyc_log[1] - out_cyc_log[0]) >= 15 && (out_cyc_log[1] - out_cyc_log[0]) <= 17), 1);
    src_q[0].push_back(mk(1'b1, 64'hD00D, 1'b0, 1'b0, 3'd0, 1'b0));
    step();
    check_int("t7_idle_flushes_late_beat", int'(in_ready[0]), 1);
`endif

    // Random soak: mixed packet lengths, orphans, source gaps, downstream stalls.
    do_reset();
    ready_pct = 70;
    gap_pct   = 25;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int p = 0; p < 10; p++) begin
        int n;
        if ($urandom_range(99) < 15)
          src_q[s].push_back(mk(1'b1, {8'hF0, 56'(p)}, 1'b0, 1'b0, 3'd0, 1'b0));
        n = $urandom_range(5, 1);
        for (int k = 0; k < n; k++) begin
          b = mk(1'b0, {$urandom, $urandom}, k == 0, k == n - 1, 3'd0, ($urandom_range(9) == 0));
          b.data[63:56] = 8'(s);
          if (k == n - 1) b.empty = 3'($urandom_range(7));
          src_q[s].push_back(b);
        end
      end
    end
    for (int k = 0; k < 6000 && pending(); k++) step();
    repeat (3) step();
    check_int("random_all_beats_delivered", int'(pending()), 0);
    ready_pct = 100;
    gap_pct   = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msg_stream_arbiter.md
Name: msg_stream_arbiter

Overview:
- Round-robin packet arbiter that shares one msg_extractor_fsm input among NUM_SRC 64-bit Avalon-ST feed sources.
- Grants at packet granularity: holds a source from startofpacket to endofpacket so message headers and payload are never interleaved.
- Registered output stage drives the extractor's in_* ports. out_channel tags which feed owns the current packet.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
CH_W, 2, width of channel index; must satisfy 2**CH_W >= NUM_SRC
TO_W, 8, width of the stall watchdog counter (used only with PKT_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  NUM_SRC  per-source beat valid
in_data  in  64*NUM_SRC  per-source data; source i occupies [64*i+63:64*i]
in_startofpacket  in  NUM_SRC  per-source SOP
in_endofpacket  in  NUM_SRC  per-source EOP
in_empty  in  3*NUM_SRC  per-source empty byte count
in_error  in  NUM_SRC  per-source error
in_ready  out  NUM_SRC  per-source ready
out_valid  out  1  beat valid to extractor
out_data  out  64  beat data
out_startofpacket  out  1  SOP
out_endofpacket  out  1  EOP
out_empty  out  3  empty bytes
out_error  out  1  error
out_channel  out  CH_W  index of source owning the beat
out_ready  in  1  downstream ready (the extractor's in_ready)

Behaviour:
- Reset: state=IDLE, grant=0, rr_ptr=0. All out_* = 0, in_ready = 0.
- Output register load condition: ld = out_ready | !out_valid. Accepted beat = in_valid[g] & in_ready[g].
- State IDLE:
  - Request vector req[i] = in_valid[i] & in_startofpacket[i].
  - Winner = first set req bit scanning from rr_ptr upward, with wrap-around.
  - If any req: register grant=winner and go to BUSY. No beat is consumed this cycle, so there is one bubble per packet.
  - Sources with in_valid=1 and in_startofpacket=0 while IDLE are orphan beats. Assert in_ready for them and discard (flush).
  - in_ready for requesting sources is 0 in IDLE.
- State BUSY:
  - in_ready[grant] = ld; all other in_ready = 0.
  - Accepted beat is registered into out_* on the next edge with out_channel=grant. Latency is 1 clock.
  - If out_valid=1 and out_ready=0, hold all out_* stable.
  - Accepted beat with EOP: next state IDLE, rr_ptr = grant+1 (wrap to 0 past NUM_SRC-1).
  - A single-beat packet (SOP&EOP) spends exactly one BUSY cycle.
  - A repeated SOP from the granted source mid-packet is forwarded unchanged and the block stays BUSY.
  - in_error is forwarded per beat. It does not release the grant; EOP does.
- Fairness: a continuously requesting source waits at most NUM_SRC-1 packets.
- Arithmetic: rr_ptr and grant are CH_W bits; wrap uses compare to NUM_SRC-1, not natural overflow.
- Reset mid-packet: everything returns to reset values immediately. A partial packet already sent downstream is the extractor's responsibility (it resets on the same reset_n).

Optional Feature:
- Macro PKT_TIMEOUT_EN.
- Defined: a TO_W-bit counter runs in BUSY.
  - Clears on every accepted beat. Increments when in_valid[grant]=0 and the output register is free.
  - On reaching all-ones: emit one beat with out_endofpacket=1, out_error=1, out_data=0, out_empty=0, out_channel=grant. Then go to IDLE with rr_ptr=grant+1.
  - Later orphan beats from that source are flushed by IDLE.
- Undefined: no counter logic; a stalled granted source holds the grant indefinitely.

Test Plan:
- Single source 0 sends 3-beat packet (SOP, mid, EOP, data 0x1111..,0x2222..,0x3333..) with out_ready=1 -> 3 output beats, out_channel=0, first out_valid 2 clocks after SOP presented (arb + register), rr_ptr=1.
- Sources 0,1,2 all hold 1-beat SOP&EOP packets continuously -> out_channel sequence 0,1,2,0,1,2, one idle cycle between beats.
- Source 3 packet in flight while source 1 raises SOP -> no source-1 beat until source-3 EOP accepted, then out_channel=1 next packet.
- out_ready low for 4 cycles mid-packet -> out_* frozen, in_ready[grant]=0, no beat lost or duplicated (data compare 5 beats).
- Source 2 presents valid without SOP in IDLE (data 0xDEAD) -> in_ready[2]=1, beat discarded, out_valid stays 0.
- PKT_TIMEOUT_EN, TO_W=4: source 0 sends SOP then stops -> after 15 stall cycles one beat with out_endofpacket=1, out_error=1, out_channel=0, state IDLE.
